// File: rtl/pipe_pkg.sv
// Shared types and defaults for the instruction pipeline register chain.
package pipe_pkg;

  localparam int unsigned PKG_DATA_W = 32;
  localparam int unsigned PKG_PC_W   = 32;
  localparam logic [PKG_DATA_W-1:0] NOP_DEFAULT = 32'h0000_0013;

  typedef struct packed {
    logic                  valid;
    logic [PKG_PC_W-1:0]   pc;
    logic [PKG_DATA_W-1:0] instr;
  } stage_t;

  // Killed stage contents: invalid, NOP instruction, zero PC.
  function automatic stage_t bubble(input logic [PKG_DATA_W-1:0] nop);
    stage_t s;
    s.valid = 1'b0;
    s.pc    = '0;
    s.instr = nop;
    return s;
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Single pipeline register: flush beats hold, hold beats load; load may be a bubble.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter logic [PKG_DATA_W-1:0] NOP_VALUE = NOP_DEFAULT
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   flush_i,
  input  logic   hold_i,
  input  logic   src_bubble_i,
  input  stage_t src_i,
  output stage_t stage_o
);

  stage_t stage_q;
  stage_t stage_d;

  always_comb begin
    stage_d = stage_q;
    if (flush_i) begin
      stage_d = bubble(NOP_VALUE);
    end else if (!hold_i) begin
      stage_d = src_bubble_i ? bubble(NOP_VALUE) : src_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stage_q <= bubble(NOP_VALUE);
    end else begin
      stage_q <= stage_d;
    end
  end

  assign stage_o = stage_q;

endmodule

// File: rtl/pipe_reg_chain.sv
// N-stage instruction pipeline register chain with stall/bubble, flush,
// output backpressure and a retired-instruction counter.
module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W     = PKG_DATA_W,
  parameter int unsigned       PC_W       = PKG_PC_W,
  parameter int unsigned       NUM_STAGES = 3,
  parameter logic [DATA_W-1:0] NOP_VALUE  = NOP_DEFAULT,
  parameter int unsigned       CNT_W      = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            in_instr,
  input  logic [PC_W-1:0]              in_pc,
  output logic                         in_ready,
  input  logic [NUM_STAGES-1:0]        stall_req,
  input  logic [NUM_STAGES-1:0]        flush,
  input  logic                         out_ready,
  output logic [NUM_STAGES-1:0]        stage_valid,
  output logic [NUM_STAGES*DATA_W-1:0] stage_instr,
  output logic [NUM_STAGES*PC_W-1:0]   stage_pc,
  output logic [CNT_W-1:0]             retired_count
);

  localparam int unsigned LAST = NUM_STAGES - 1;

  stage_t                stage_q    [NUM_STAGES];
  stage_t                src        [NUM_STAGES];
  logic [NUM_STAGES-1:0] hold;
  logic [NUM_STAGES-1:0] src_bubble;
  logic                  retire;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;

  // Hold ripples from the oldest register down; built in a local to keep the chain acyclic.
  always_comb begin
    logic [NUM_STAGES-1:0] h;
    h       = '0;
    h[LAST] = stall_req[LAST] | (stage_q[LAST].valid & ~out_ready);
    for (int unsigned i = 1; i < NUM_STAGES; i++) begin
      h[LAST-i] = stall_req[LAST-i] | h[LAST-i+1];
    end
    hold = h;
  end

  assign in_ready = ~hold[0];

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign src[g]        = '{valid: in_valid, pc: in_pc, instr: in_instr};
      assign src_bubble[g] = ~in_valid;
    end else begin : g_body
      assign src[g]        = stage_q[g-1];
      assign src_bubble[g] = hold[g-1];
    end

    pipe_stage_reg #(
      .NOP_VALUE(NOP_VALUE)
    ) u_reg (
      .clk_i       (clk),
      .rst_i       (rst),
      .flush_i     (flush[g]),
      .hold_i      (hold[g]),
      .src_bubble_i(src_bubble[g]),
      .src_i       (src[g]),
      .stage_o     (stage_q[g])
    );

    assign stage_valid[g]               = stage_q[g].valid;
    assign stage_instr[g*DATA_W +: DATA_W] = stage_q[g].instr;
    assign stage_pc[g*PC_W +: PC_W]        = stage_q[g].pc;
  end

  assign retire = stage_q[LAST].valid & out_ready & ~flush[LAST];

  always_comb begin
    cnt_d = cnt_q;
    if (retire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign retired_count = cnt_q;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed bench for pipe_reg_chain (3 stages, 4-bit retired counter).
module tb_pipe_reg_chain;

  localparam int unsigned N   = 3;
  localparam int unsigned DW  = 32;
  localparam int unsigned PW  = 32;
  localparam int unsigned CW  = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic [DW-1:0]   in_instr;
  logic [PW-1:0]   in_pc;
  logic            in_ready;
  logic [N-1:0]    stall_req;
  logic [N-1:0]    flush;
  logic            out_ready;
  logic [N-1:0]    stage_valid;
  logic [N*DW-1:0] stage_instr;
  logic [N*PW-1:0] stage_pc;
  logic [CW-1:0]   retired_count;

  int checks = 0;
  int errors = 0;

  pipe_reg_chain #(
    .DATA_W    (DW),
    .PC_W      (PW),
    .NUM_STAGES(N),
    .NOP_VALUE (NOP),
    .CNT_W     (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_instr     (in_instr),
    .in_pc        (in_pc),
    .in_ready     (in_ready),
    .stall_req    (stall_req),
    .flush        (flush),
    .out_ready    (out_ready),
    .stage_valid  (stage_valid),
    .stage_instr  (stage_instr),
    .stage_pc     (stage_pc),
    .retired_count(retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_stage(input string tag, input int k, input logic v,
                           input logic [31:0] ins, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'b0, stage_valid[k]}, {31'b0, v});
    chk({tag, "_instr"}, stage_instr[k*DW +: DW], ins);
    chk({tag, "_pc"},    stage_pc[k*PW +: PW], pc);
  endtask

  task automatic chk_bub(input string tag, input int k);
    chk_stage(tag, k, 1'b0, NOP, 32'h0);
  endtask

  task automatic chk_cnt(input string tag, input logic [3:0] exp_c);
    chk(tag, {28'b0, retired_count}, {28'b0, exp_c});
  endtask

  task automatic chk_rdy(input string tag, input logic exp_r);
    chk(tag, {31'b0, in_ready}, {31'b0, exp_r});
  endtask

  task automatic feed(input logic [31:0] ins, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    stall_req = '0;
    flush     = '0;
    out_ready = 1'b1;
    #12;
    for (int k = 0; k < 3; k++) chk_bub("reset_stage", k);
    chk_cnt("reset_cnt", 4'd0);
    chk_rdy("reset_rdy", 1'b1);
    rst = 1'b0;

    // Streaming
    feed(32'hA1, 32'h0);
    chk_rdy("stream_rdy0", 1'b1);
    feed(32'hA2, 32'h4);
    chk_rdy("stream_rdy1", 1'b1);
    feed(32'hA3, 32'h8);
    in_valid = 1'b0;
    chk_stage("stream_s2_a1", 2, 1'b1, 32'hA1, 32'h0);
    chk_stage("stream_s1_a2", 1, 1'b1, 32'hA2, 32'h4);
    chk_stage("stream_s0_a3", 0, 1'b1, 32'hA3, 32'h8);
    chk_cnt("stream_cnt0", 4'd0);
    chk_rdy("stream_rdy2", 1'b1);
    tick();
    chk_stage("stream_s2_a2", 2, 1'b1, 32'hA2, 32'h4);
    chk_cnt("stream_cnt1", 4'd1);
    tick();
    chk_stage("stream_s2_a3", 2, 1'b1, 32'hA3, 32'h8);
    chk_cnt("stream_cnt2", 4'd2);
    tick();
    chk_bub("stream_s2_empty", 2);
    chk_bub("stream_s0_empty", 0);
    chk_cnt("stream_cnt3", 4'd3);

    // Load-use stall on register 0
    feed(32'hB0, 32'h10);
    feed(32'hB1, 32'h14);
    in_instr  = 32'hB2;
    in_pc     = 32'h18;
    stall_req = 3'b001;
    #1;
    chk_rdy("stall_rdy", 1'b0);
    tick();
    chk_stage("stall_s0_keep", 0, 1'b1, 32'hB1, 32'h14);
    chk_bub("stall_s1_bubble", 1);
    chk_stage("stall_s2_b0", 2, 1'b1, 32'hB0, 32'h10);
    chk_cnt("stall_cnt", 4'd3);
    stall_req = 3'b000;
    #1;
    chk_rdy("stall_release_rdy", 1'b1);
    tick();
    chk_stage("stall_s0_b2", 0, 1'b1, 32'hB2, 32'h18);
    chk_stage("stall_s1_b1", 1, 1'b1, 32'hB1, 32'h14);
    chk_bub("stall_s2_bubble", 2);
    chk_cnt("stall_cnt_b0", 4'd4);
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    chk_cnt("stall_drain_cnt", 4'd6);

    // Mispredict flush of registers 0 and 1
    feed(32'hC0, 32'h20);
    feed(32'hC1, 32'h24);
    feed(32'hC2, 32'h28);
    chk_stage("flush_pre_s2", 2, 1'b1, 32'hC0, 32'h20);
    in_instr = 32'hC3;
    in_pc    = 32'h2C;
    flush    = 3'b011;
    #1;
    chk_rdy("flush_rdy", 1'b1);
    tick();
    chk_bub("flush_s0", 0);
    chk_bub("flush_s1", 1);
    chk_stage("flush_s2_c1", 2, 1'b1, 32'hC1, 32'h24);
    chk_cnt("flush_cnt_c0", 4'd7);
    flush    = 3'b000;
    in_valid = 1'b0;
    tick();
    chk_bub("flush_s2_after", 2);
    chk_cnt("flush_cnt_c1", 4'd8);

    // Simultaneous stall and flush on register 1
    feed(32'hD0, 32'h30);
    feed(32'hD1, 32'h34);
    feed(32'hD2, 32'h38);
    in_instr  = 32'hD3;
    in_pc     = 32'h3C;
    stall_req = 3'b010;
    flush     = 3'b010;
    #1;
    chk_rdy("sf_rdy", 1'b0);
    tick();
    chk_stage("sf_s0_hold", 0, 1'b1, 32'hD2, 32'h38);
    chk_bub("sf_s1_flushed", 1);
    chk_bub("sf_s2_bubble", 2);
    chk_cnt("sf_cnt", 4'd9);
    stall_req = 3'b000;
    flush     = 3'b000;
    tick();
    chk_stage("sf_s0_d3", 0, 1'b1, 32'hD3, 32'h3C);
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    chk_cnt("sf_drain_cnt", 4'd11);

    // Backpressure with a valid last stage
    feed(32'hE0, 32'h40);
    feed(32'hE1, 32'h44);
    feed(32'hE2, 32'h48);
    in_instr  = 32'hE3;
    in_pc     = 32'h4C;
    out_ready = 1'b0;
    #1;
    chk_rdy("bp_rdy", 1'b0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk_stage("bp_s0", 0, 1'b1, 32'hE2, 32'h48);
      chk_stage("bp_s1", 1, 1'b1, 32'hE1, 32'h44);
      chk_stage("bp_s2", 2, 1'b1, 32'hE0, 32'h40);
      chk_cnt("bp_cnt", 4'd11);
      chk_rdy("bp_rdy_hold", 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    chk_cnt("bp_drain_cnt", 4'd14);

    // Backpressure with an empty last stage does not stall
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'hF0;
    in_pc     = 32'h50;
    #1;
    chk_rdy("bpe_rdy0", 1'b1);
    tick();
    in_valid = 1'b0;
    chk_stage("bpe_s0", 0, 1'b1, 32'hF0, 32'h50);
    chk_rdy("bpe_rdy1", 1'b1);
    tick();
    chk_stage("bpe_s1", 1, 1'b1, 32'hF0, 32'h50);
    tick();
    chk_stage("bpe_s2", 2, 1'b1, 32'hF0, 32'h50);
    chk_rdy("bpe_rdy_full", 1'b0);
    chk_cnt("bpe_cnt_hold", 4'd14);
    out_ready = 1'b1;
    tick();
    chk_cnt("bpe_cnt", 4'd15);

    // Asynchronous reset between edges with every stage valid
    feed(32'h60, 32'h60);
    feed(32'h61, 32'h64);
    feed(32'h62, 32'h68);
    in_valid = 1'b0;
    chk_stage("arst_pre_s2", 2, 1'b1, 32'h60, 32'h60);
    #2;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) chk_bub("arst_stage", k);
    chk_cnt("arst_cnt", 4'd0);
    #2;
    rst = 1'b0;

    // Counter wrap: 17 retirements on a 4-bit counter
    feed(32'h100, 32'h0);
    chk_stage("wrap_first", 0, 1'b1, 32'h100, 32'h0);
    for (int i = 1; i < 17; i++) begin
      feed(32'h100 + 32'(i), 32'(i * 4));
    end
    in_valid = 1'b0;
    tick();
    tick();
    chk_cnt("wrap_cnt16", 4'd0);
    tick();
    chk_cnt("wrap_cnt17", 4'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
